// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared FSM encoding, prescaler width and tick decode for the PWM capture block.
package pwm_capture_pkg;
  localparam int PS_W = 15;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_MEASURE = 2'd2,
    ST_STALL   = 2'd3
  } cap_state_e;
  function automatic logic ps_tick(input logic [PS_W-1:0] ps, input logic [3:0] k);
    logic [PS_W-1:0] mask;
    mask = PS_W'((32'd1 << k) - 32'd1);
    return (ps & mask) == mask;
  endfunction
endpackage

// File: rtl/pwm_capture_channel.sv
// pwm_capture_channel: one capture lane -- input synchronizer, rising-edge detect,
// measurement FSM with period/high counters and the published capture registers.
module pwm_capture_channel
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             tick_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             level_o,
  output logic             timeout_o
);
  cap_state_e             state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q, valid_q, level_q, timeout_q;
  logic [CNT_W-1:0]       period_q, high_q, cap_period_q, cap_high_q;
  logic                   sync_d, rise_d, ovf_d;
  logic [CNT_W-1:0]       period_d, high_d, reload_d;
  always_comb begin
    sync_d   = sync_q[SYNC_STAGES-1];
    rise_d   = sync_d & ~prev_q;
    ovf_d    = tick_i & (&period_q);
    period_d = tick_i ? period_q + CNT_W'(1) : period_q;
    high_d   = (tick_i && sync_d && !(&high_q)) ? high_q + CNT_W'(1) : high_q;
    reload_d = tick_i ? CNT_W'(1) : '0;
  end
  // The edge cycle itself is the first cycle of the new period, hence the tick-dependent reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      valid_q      <= 1'b0;
      level_q      <= 1'b0;
      timeout_q    <= 1'b0;
      period_q     <= '0;
      high_q       <= '0;
      cap_period_q <= '0;
      cap_high_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      prev_q  <= sync_d;
      valid_q <= 1'b0;
      if (clr_i) timeout_q <= 1'b0;
      if (!en_i) begin
        state_q   <= ST_IDLE;
        period_q  <= '0;
        high_q    <= '0;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_WAIT;
          ST_WAIT, ST_MEASURE: begin
            if (rise_d) begin
              if (state_q == ST_MEASURE) begin
                cap_period_q <= period_q;
                cap_high_q   <= high_q;
                valid_q      <= 1'b1;
              end
              state_q  <= ST_MEASURE;
              period_q <= reload_d;
              high_q   <= reload_d;
            end else if (ovf_d) begin
              cap_period_q <= '1;
              cap_high_q   <= sync_d ? '1 : '0;
              level_q      <= sync_d;
              timeout_q    <= 1'b1;
              valid_q      <= 1'b1;
              state_q      <= ST_STALL;
            end else begin
              period_q <= period_d;
              if (state_q == ST_MEASURE) high_q <= high_d;
            end
          end
          ST_STALL: if (rise_d) begin
            state_q  <= ST_MEASURE;
            period_q <= reload_d;
            high_q   <= reload_d;
          end
        endcase
      end
    end
  end
  assign period_o  = cap_period_q;
  assign high_o    = cap_high_q;
  assign valid_o   = valid_q;
  assign level_o   = level_q;
  assign timeout_o = timeout_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: shared free-running prescaler feeding NUM_CH independent PWM capture channels.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       pwm_in,
  input  logic [7:0]              reg_cap_en,
  input  logic [7:0]              reg_cap_clr,
  input  logic [7:0]              reg_cap_prescale,
  output logic [NUM_CH*CNT_W-1:0] cap_period,
  output logic [NUM_CH*CNT_W-1:0] cap_high,
  output logic [NUM_CH-1:0]       cap_valid,
  output logic [NUM_CH-1:0]       cap_level,
  output logic [NUM_CH-1:0]       cap_timeout
);
  logic [PS_W-1:0] ps_q;
  logic            tick;
  logic            unused_ps_hi;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ps_q <= '0;
    else ps_q <= ps_q + PS_W'(1);
  end
  assign tick         = ps_tick(ps_q, reg_cap_prescale[3:0]);
  assign unused_ps_hi = ^reg_cap_prescale[7:4];
  if (NUM_CH < 8) begin : g_unused
    logic unused_ch;
    assign unused_ch = ^{reg_cap_en[7:NUM_CH], reg_cap_clr[7:NUM_CH]};
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_capture_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_i     (pwm_in[c]),
      .en_i      (reg_cap_en[c]),
      .clr_i     (reg_cap_clr[c]),
      .tick_i    (tick),
      .period_o  (cap_period[c*CNT_W +: CNT_W]),
      .high_o    (cap_high[c*CNT_W +: CNT_W]),
      .valid_o   (cap_valid[c]),
      .level_o   (cap_level[c]),
      .timeout_o (cap_timeout[c])
    );
  end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM input capture block: the receive-side counterpart of the PWM generator peripheral. It samples up to `NUM_CH` external PWM inputs and measures period and high time of each, in prescaled clock ticks. It publishes the latest measurement per channel with a one-cycle valid strobe, and flags stalled (non-toggling) inputs. It sits beside the PWM generator behind the SPI register file, which supplies the control inputs and reads the capture outputs.

## Interface
- `NUM_CH`, default 4: number of capture channels (1..8).
- `CNT_W`, default 16: width of the period and high-time counters.
- `SYNC_STAGES`, default 2: synchronizer flops per input (at least 2).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `pwm_in`  in  NUM_CH  asynchronous PWM inputs.
- `reg_cap_en`  in  8  per-channel enable; bits `[NUM_CH-1:0]` are used.
- `reg_cap_clr`  in  8  per-channel single-cycle pulse that clears `cap_timeout`.
- `reg_cap_prescale`  in  8  bits `[3:0]` = k; one tick every 2^k clocks; bits `[7:4]` are ignored.
- `cap_period`  out  NUM_CH*CNT_W  last captured period in ticks; channel i occupies `[i*CNT_W +: CNT_W]`.
- `cap_high`  out  NUM_CH*CNT_W  last captured high time in ticks, same packing.
- `cap_valid`  out  NUM_CH  one-cycle strobe when channel i updates its captured values.
- `cap_level`  out  NUM_CH  synchronized input level latched at timeout.
- `cap_timeout`  out  NUM_CH  sticky flag: the input stalled.

## Operation
- **Prescaler:** shared, free-running 15-bit counter `ps`.
  - mask = (1<<k)-1; `tick` = ((ps & mask) == mask).
  - k=0 gives a tick every cycle.
  - Changing k takes effect the next cycle; no counter reset.
- **Per channel:** `SYNC_STAGES` synchronizer flops, then one `prev` flop. `rise` = sync & ~prev.
- **Per-channel FSM:**
  - **IDLE:** `reg_cap_en[i]`=0. Counters are 0; captured values hold. `cap_timeout[i]` is cleared. Enable=1 moves to WAIT.
  - **WAIT:** Each tick, `period_cnt` increments. On `rise`: go to MEASURE; counters load (tick?1:0); no capture.
  - **MEASURE:** Each tick, `period_cnt` increments, and `high_cnt` increments if sync=1. On `rise`:
    - `cap_period` <= `period_cnt`, `cap_high` <= `high_cnt`, and `cap_valid` pulses.
    - Counters reload (tick?1:0), so the edge cycle counts toward the new period.
  - **STALL:** Counters are frozen. On `rise`: go to MEASURE with counters reloaded (tick?1:0); no capture.
- **Timeout:** in WAIT or MEASURE, when a tick would take `period_cnt` past all-ones:
  - `cap_period` <= all-ones.
  - `cap_high` <= all-ones if sync=1, else 0.
  - `cap_level` <= sync; `cap_timeout` <= 1; `cap_valid` pulses once.
  - FSM goes to STALL.
- **Saturation:** `high_cnt` saturates at all-ones. It cannot exceed `period_cnt`.
- **Disable:** enable dropping in any state forces IDLE on the next edge. A coincident capture is discarded.
- **Clear vs set:** `reg_cap_clr[i]` in the same cycle as a timeout set → the set wins.
- **Channel independence:** channels share only the prescaler.

## Timing
- **Reset values:**
  - All outputs 0.
  - Every FSM in IDLE.
  - Synchronizers, `prev`, `ps` and all counters 0.
- **Capture latency:** `pwm_in` first sampled high at edge e0 → `cap_*` updated and `cap_valid`=1 after edge e0+`SYNC_STAGES`. Output is fully registered.
- **Strobe:** `cap_valid` is high for exactly one cycle per capture or timeout.
- **Minimum pulse:** pulses shorter than one clock may be missed. No glitch filtering.
- **Async reset mid-measurement:** all state is lost and FSMs return to IDLE. Previously captured values are reset to 0.

## Structure
- Package `pwm_capture_pkg`:
  - FSM state encodings: IDLE=2'd0, WAIT=2'd1, MEASURE=2'd2, STALL=2'd3.
  - Prescaler width constant (15).
- Sub-module `pwm_capture_channel`: synchronizer, edge detect, FSM, counters and capture registers for one channel.
- Top level: prescaler plus a generate loop over `NUM_CH`.

## Test plan
- **Loopback, k=0:** PWM generator output, divider 0, duty 64 → `cap_period`=512, `cap_high`=128 on every `cap_valid` after the first full period.
- **Prescale change:** same stimulus, k=1 → `cap_period`=256, `cap_high`=64.
- **Latency:** square wave period 10 clk, high 3 clk, k=0 →
  - First `rise` gives no strobe.
  - Each subsequent strobe reports 10/3.
  - Strobe appears exactly 2 clk after the sampling edge.
- **Timeout high:** `CNT_W`=8 and input held high after one `rise` →
  - After 255 ticks: `cap_timeout`=1, `cap_level`=1, `cap_period`=255, `cap_high`=255, a single strobe.
  - `reg_cap_clr` then clears the flag.
- **Stuck low from enable:** input held low from enable → the timeout fires from WAIT with `cap_high`=0 and `cap_level`=0.
- **Mid-period disable and reset:**
  - Enable dropped mid-period → no strobe; captured values hold.
  - `rst_n` asserted mid-period → all outputs 0 immediately.
  - After re-enable, the first valid capture occurs one full period after the first `rise`.
